// File: rtl/inst_mem_responder.sv
// Instruction memory responder for the processor fetch side.
// Multi-cycle miss latency with a one-entry last-fetch register.
module inst_mem_responder #(
    parameter int          ADDR_BITS = 10,
    parameter int          LATENCY   = 4,
    parameter logic [31:0] NOP_WORD  = 32'h0800_0000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 READ,
    input  logic [31:0]          ADDRESS,
    output logic [31:0]          INSTRUCTION,
    output logic                 BUSYWAIT,
    output logic                 ERROR,
    input  logic                 LOAD_EN,
    input  logic [ADDR_BITS-1:0] LOAD_ADDR,
    input  logic [7:0]           LOAD_DATA
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t state, state_n;

    logic [7:0]           mem [DEPTH];
    logic [CW-1:0]        count;
    logic [ADDR_BITS-1:0] laddr;
    logic [ADDR_BITS-1:0] tag;
    logic                 valid;
    logic                 squash;
    logic [31:0]          instruction;
    logic                 error;
    logic                 busy;
    logic                 legal;
    logic                 hit;
    logic                 ld_tag;
    logic                 ld_laddr;
    logic [31:0]          rd_word;

    assign legal = (ADDRESS[1:0] == 2'b00) &&
                   (ADDRESS[31:ADDR_BITS] == '0);
    assign hit = valid && (ADDRESS == 32'(tag));

    assign ld_tag = LOAD_EN &&
        (LOAD_ADDR[ADDR_BITS-1:2] == tag[ADDR_BITS-1:2]);
    assign ld_laddr = LOAD_EN &&
        (LOAD_ADDR[ADDR_BITS-1:2] == laddr[ADDR_BITS-1:2]);

    // laddr is word aligned, so the four bytes never wrap
    assign rd_word = {mem[laddr + ADDR_BITS'(3)],
                      mem[laddr + ADDR_BITS'(2)],
                      mem[laddr + ADDR_BITS'(1)],
                      mem[laddr]};

    assign INSTRUCTION = instruction;
    assign ERROR       = error;
    assign BUSYWAIT    = busy;

    // Program-load byte port; contents survive reset
    always_ff @(posedge CLK) begin
        if (LOAD_EN) begin
            mem[LOAD_ADDR] <= LOAD_DATA;
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and stall: a miss stalls from its request cycle on
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        unique case (state)
            IDLE: begin
                if (READ && legal && !hit) begin
                    busy    = 1'b1;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                busy = 1'b1;
                if (count == '0) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Fetch datapath: latency counter, last-fetch tag and outputs
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            instruction <= '0;
            error       <= 1'b0;
            count       <= '0;
            valid       <= 1'b0;
            tag         <= '0;
            laddr       <= '0;
            squash      <= 1'b0;
        end else begin
            error <= 1'b0;
            if (ld_tag) begin
                valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (READ) begin
                        if (!legal) begin
                            instruction <= NOP_WORD;
                            error       <= 1'b1;
                            valid       <= 1'b0;
                        end else if (!hit) begin
                            laddr  <= ADDRESS[ADDR_BITS-1:0];
                            count  <= CNT_INIT;
                            squash <= 1'b0;
                        end
                    end
                end
                FETCH: begin
                    if (count != '0) begin
                        count <= count - CW'(1);
                        if (ld_laddr) begin
                            squash <= 1'b1;
                        end
                    end else begin
                        instruction <= rd_word;
                        tag         <= laddr;
                        valid       <= !(squash || ld_laddr);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
